// File: rtl/bit_ram_capture_ctrl.sv
// Capture sequencer for a 1-bit single-clock RAM with registered read:
// records a triggered serial bit stream, then replays it over valid/ready.
module bit_ram_capture_ctrl #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              trig,
  input  logic              bit_in,
  input  logic              bit_in_valid,
  input  logic              rd_start,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  output logic              m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic              ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FULL    = 3'd3,
    READ    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t state_reg, state_next;

  logic [ADDR_W:0] len_reg;
  logic [ADDR_W:0] wp_reg;
  logic [ADDR_W:0] rp_reg;
  logic [ADDR_W:0] beat_reg;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] wp_inc;

  logic            arm_ok;
  logic            rd_go;
  logic            cap_write;
  logic            last_write;

  // Read-side pipeline: one beat in flight in the RAM output register,
  // plus a two-entry buffer that absorbs it when the consumer stalls.
  logic            rd_pend_reg;
  logic [1:0]      fifo_mem_reg;
  logic            fifo_wptr_reg;
  logic            fifo_rptr_reg;
  logic [1:0]      fifo_cnt_reg;
  logic            fifo_empty;
  logic [1:0]      occ;
  logic            head_data;
  logic            out_valid;
  logic            out_last;
  logic            pop;
  logic            fifo_pop;
  logic            push;
  logic            issue;
  logic            rd_flush;

  assign len_clamped = (cfg_len == '0 || cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign arm_ok      = !abort && arm && (state_reg == IDLE || state_reg == FULL);
  assign rd_go       = !abort && !arm && rd_start && (state_reg == FULL);

  assign cap_write = rst_n && !abort &&
                     ((state_reg == ARMED && trig && bit_in_valid) ||
                      (state_reg == CAPTURE && bit_in_valid));
  assign wp_inc     = (state_reg == ARMED) ? ONE : wp_reg + ONE;
  assign last_write = cap_write && (wp_inc == len_reg);

  assign fifo_empty = (fifo_cnt_reg == 2'd0);
  assign occ        = fifo_cnt_reg + {1'b0, rd_pend_reg};
  assign head_data  = fifo_empty ? ram_rdata : fifo_mem_reg[fifo_rptr_reg];
  assign out_valid  = (state_reg == READ) && (!fifo_empty || rd_pend_reg);
  assign out_last   = out_valid && (beat_reg == len_reg - ONE);
  assign pop        = out_valid && m_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign push       = rd_pend_reg && !(fifo_empty && pop);
  assign rd_flush   = abort || (state_reg != READ) || (pop && out_last);

  // Only issue when the buffer is guaranteed to have room for the beat
  // even if the consumer stalls on the cycle that beat returns.
  assign issue = (state_reg == READ) && !abort && (rp_reg < len_reg) &&
                 ((occ - {1'b0, pop}) <= 2'd1);

  assign m_valid   = out_valid;
  assign m_data    = out_valid & head_data;
  assign m_last    = out_last;
  assign ram_raddr = issue ? rp_reg[ADDR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (arm) state_next = ARMED;
        ARMED:   if (trig && bit_in_valid) state_next = (len_reg == ONE) ? FULL : CAPTURE;
        CAPTURE: if (last_write) state_next = FULL;
        FULL: begin
          if (arm)           state_next = ARMED;
          else if (rd_start) state_next = READ;
        end
        READ:    if (pop && out_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_reg == ARMED) || (state_reg == CAPTURE) || (state_reg == READ);
    done      = (state_reg == FULL);
    ram_we    = cap_write;
    ram_waddr = (state_reg == CAPTURE) ? wp_reg[ADDR_W-1:0] : '0;
    ram_wdata = cap_write & bit_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_reg     <= '0;
      wp_reg      <= '0;
      rp_reg      <= '0;
      beat_reg    <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      if (arm_ok) begin
        len_reg <= len_clamped;
      end

      if (arm_ok) begin
        wp_reg <= '0;
      end else if (cap_write) begin
        wp_reg <= wp_inc;
      end

      if (rd_go) begin
        rp_reg   <= '0;
        beat_reg <= '0;
      end else begin
        if (issue) rp_reg   <= rp_reg + ONE;
        if (pop)   beat_reg <= beat_reg + ONE;
      end

      rd_pend_reg <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rd_flush) begin
      fifo_wptr_reg <= 1'b0;
      fifo_rptr_reg <= 1'b0;
      fifo_cnt_reg  <= 2'd0;
    end else begin
      if (push)     fifo_wptr_reg <= ~fifo_wptr_reg;
      if (fifo_pop) fifo_rptr_reg <= ~fifo_rptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        fifo_mem_reg[gi] <= 1'b0;
      end else if (push && fifo_wptr_reg == 1'(gi)) begin
        fifo_mem_reg[gi] <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bit_ram_capture_ctrl.sv
// Directed bench for bit_ram_capture_ctrl: drives captures and readouts and
// checks every cycle against a phase-level behavioural model plus literals.
module tb_bit_ram_capture_ctrl;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   cfg_len = '0;
  logic              trig = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_in_valid = 1'b0;
  logic              rd_start = 1'b0;
  logic              busy, done, m_valid, m_data, m_last;
  logic              m_ready = 1'b0;
  logic              ram_we, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic              ram_rdata;

  bit_ram_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .cfg_len(cfg_len),
    .trig(trig), .bit_in(bit_in), .bit_in_valid(bit_in_valid), .rd_start(rd_start),
    .busy(busy), .done(done), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // The RAM the controller drives: single clock, registered read.
  logic ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [DEPTH-1:0] act, input logic [DEPTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Behavioural model: capture phase, stored bits, delivery progress.
  typedef enum int {M_IDLE, M_ARMED, M_CAPTURE, M_FULL, M_READ} mphase_t;
  mphase_t ms = M_IDLE;
  int      m_len = 0;
  int      m_wp = 0;
  int      m_beat = 0;
  int      m_rcyc = 0;
  logic    exp_mem [DEPTH];

  // Monitor tallies read by the stimulus for literal expectations.
  int               cyc = 0;
  int               wr_count = 0;
  int               last_waddr = -1;
  int               beat_idx = 0;
  int               last_cnt = 0;
  int               start_cyc = 0;
  int               first_lat = -1;
  logic [DEPTH-1:0] rd_bits = '0;

  initial begin
    logic e_busy, e_done, e_we, e_mv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      e_busy = (ms == M_ARMED) || (ms == M_CAPTURE) || (ms == M_READ);
      e_done = (ms == M_FULL);
      e_we   = rst_n && !abort &&
               ((ms == M_ARMED && trig && bit_in_valid) || (ms == M_CAPTURE && bit_in_valid));
      e_mv   = (ms == M_READ) && (m_rcyc >= 1);

      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("ram_we", ram_we, e_we);
      check("m_valid", m_valid, e_mv);
      if (e_we) begin
        check("ram_waddr", ram_waddr, (ms == M_ARMED) ? 0 : m_wp);
        check("ram_wdata", ram_wdata, bit_in);
      end
      if (e_mv) begin
        check("m_data", m_data, exp_mem[m_beat]);
        check("m_last", m_last, (m_beat == m_len - 1));
      end
      if (ms == M_READ) check("raddr_below_len", (int'(ram_raddr) < m_len), 1);

      if (ram_we) begin
        wr_count++;
        last_waddr = ram_waddr;
        $display("WR addr=%0d data=%0b", ram_waddr, ram_wdata);
      end
      if (m_valid && first_lat < 0) first_lat = cyc - start_cyc;
      if (m_valid && m_ready) begin
        rd_bits[beat_idx] = m_data;
        if (m_last) last_cnt++;
        $display("RD beat=%0d data=%0b last=%0b", beat_idx, m_data, m_last);
        beat_idx++;
      end

      if (!rst_n || abort) begin
        ms = M_IDLE;
      end else begin
        case (ms)
          M_IDLE: if (arm) begin
            ms    = M_ARMED;
            m_len = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
            m_wp  = 0;
          end
          M_ARMED: if (trig && bit_in_valid) begin
            exp_mem[0] = bit_in;
            m_wp = 1;
            ms = (m_len == 1) ? M_FULL : M_CAPTURE;
          end
          M_CAPTURE: if (bit_in_valid) begin
            exp_mem[m_wp] = bit_in;
            m_wp++;
            if (m_wp == m_len) ms = M_FULL;
          end
          M_FULL: begin
            if (arm) begin
              ms    = M_ARMED;
              m_len = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
              m_wp  = 0;
            end else if (rd_start) begin
              ms = M_READ;
              m_beat = 0;
              m_rcyc = 0;
              beat_idx = 0;
              last_cnt = 0;
              rd_bits = '0;
              start_cyc = cyc;
              first_lat = -1;
            end
          end
          M_READ: begin
            m_rcyc++;
            if (e_mv && m_ready) begin
              if (m_beat == m_len - 1) ms = M_IDLE;
              m_beat++;
            end
          end
          default: ms = M_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int len);
    cfg_len = (ADDR_W+1)'(len);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic capture(input logic [DEPTH-1:0] pat, input int n, input bit gaps, input bit first);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) tick();
      bit_in = pat[i];
      bit_in_valid = 1'b1;
      trig = first && (i == 0);
      tick();
      bit_in_valid = 1'b0;
      trig = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 8 && !done; k++) tick();
    check("done_after_capture", done, 1);
  endtask

  // mode 0: m_ready held high, 1: random m_ready
  task automatic do_read(input int mode);
    rd_start = 1'b1;
    m_ready = (mode == 0);
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 4 * DEPTH + 20 && busy; k++) begin
      m_ready = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      tick();
    end
    check("read_terminates", busy, 0);
    check("done_after_read", done, 0);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [DEPTH-1:0] pat;
    int w0;

    // 1. reset with control inputs active
    arm = 1'b1; trig = 1'b1; bit_in_valid = 1'b1; bit_in = 1'b1; cfg_len = 9'd4;
    repeat (3) tick();
    check("reset_writes", wr_count, 0);
    check("reset_busy", busy, 0);
    arm = 1'b0; trig = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2. basic capture of 8 bits with gaps, then full-rate readout
    w0 = wr_count;
    do_arm(8);
    capture(8'h4D, 8, 1'b1, 1'b1);
    wait_done();
    check("basic_writes", wr_count - w0, 8);
    check("basic_last_addr", last_waddr, 7);
    do_read(0);
    check_vec("basic_bits", rd_bits, 8'h4D);
    check("basic_latency", first_lat, 2);
    check("basic_beats", beat_idx, 8);
    check("basic_last_cnt", last_cnt, 1);

    // 3. backpressure on a 16-bit capture
    do_arm(16);
    capture(16'hA5C3, 16, 1'b1, 1'b1);
    wait_done();
    do_read(1);
    check_vec("bp_bits", rd_bits, 16'hA5C3);
    check("bp_beats", beat_idx, 16);
    check("bp_last_cnt", last_cnt, 1);

    // 4a. cfg_len = 0 clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) pat[i] = 1'($urandom_range(0, 1));
    w0 = wr_count;
    do_arm(0);
    capture(pat, DEPTH, 1'b0, 1'b1);
    wait_done();
    check("clamp_writes", wr_count - w0, DEPTH);
    check("clamp_last_addr", last_waddr, DEPTH - 1);
    do_read(1);
    check_vec("clamp_bits", rd_bits, pat);
    check("clamp_beats", beat_idx, DEPTH);
    check("clamp_last_cnt", last_cnt, 1);

    // 4b. single-bit capture goes straight to FULL
    do_arm(1);
    capture(1'b1, 1, 1'b0, 1'b1);
    check("len1_done", done, 1);
    do_read(0);
    check_vec("len1_bits", rd_bits, 1);
    check("len1_beats", beat_idx, 1);
    check("len1_last_cnt", last_cnt, 1);

    // 5a. abort after 5 of 10 bits
    w0 = wr_count;
    do_arm(10);
    capture(10'h2B5, 5, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_cap_busy", busy, 0);
    capture(10'h3FF, 3, 1'b0, 1'b0);
    check("abort_cap_writes", wr_count - w0, 5);

    // 5b. abort during readout with a beat pending
    do_arm(4);
    capture(4'hA, 4, 1'b0, 1'b1);
    wait_done();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 8 && !m_valid; k++) tick();
    check("abort_rd_pending", m_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rd_valid", m_valid, 0);
    check("abort_rd_done", done, 0);

    // 5c. new capture after abort returns only new data
    do_arm(4);
    capture(4'h6, 4, 1'b0, 1'b1);
    wait_done();
    do_read(0);
    check_vec("post_abort_bits", rd_bits, 4'h6);
    check("post_abort_beats", beat_idx, 4);

    // 6. ignored rd_start in ARMED, ignored arm in CAPTURE, re-arm in FULL
    do_arm(6);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("rdstart_armed_busy", busy, 1);
    w0 = wr_count;
    capture(6'h05, 3, 1'b0, 1'b1);
    cfg_len = 9'd2;
    arm = 1'b1;
    capture(6'h01, 1, 1'b0, 1'b0);
    arm = 1'b0;
    check("arm_in_capture_done", done, 0);
    capture(6'h03, 2, 1'b0, 1'b0);
    wait_done();
    check("ignored_arm_writes", wr_count - w0, 6);
    do_arm(3);
    check("rearm_done", done, 0);
    check("rearm_busy", busy, 1);
    capture(3'h5, 3, 1'b0, 1'b1);
    wait_done();
    do_read(0);
    check_vec("rearm_bits", rd_bits, 3'h5);
    check("rearm_beats", beat_idx, 3);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
